// File: rtl/tpu_ctrl_pkg.sv
// Shared opcodes, FSM state encoding and helpers for the TPU sequencing controller.
package tpu_ctrl_pkg;

  localparam logic [6:0] OP_MATMUL = 7'h50;
  localparam logic [6:0] OP_LAM    = 7'h51;
  localparam logic [6:0] OP_LBM    = 7'h52;
  localparam logic [6:0] OP_LACC   = 7'h53;
  localparam logic [6:0] OP_RACC   = 7'h54;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    MM    = 2'd2,
    STORE = 2'd3
  } tpu_state_e;

  function automatic logic is_tpu_op(input logic [6:0] op);
    return (op >= OP_MATMUL) && (op <= OP_RACC);
  endfunction

  // A single-row array still needs a 1-bit row index.
  function automatic int row_w(input int dim);
    return (dim > 1) ? $clog2(dim) : 1;
  endfunction

endpackage

// File: rtl/tpu_seq_ctrl_if.sv
// Decode-side request and memory/TPU-buffer control bundle of the TPU sequencer.
// TPU_PERF_CNT_EN adds the perf_busy_cycles signal.
interface tpu_seq_ctrl_if #(
  parameter int DIM    = 8,
  parameter int ADDR_W = 16
);
  localparam int ROW_W = tpu_ctrl_pkg::row_w(DIM);

  logic [6:0]        op;
  logic              op_valid;
  logic [ADDR_W-1:0] base_addr;
  logic              stall;
  logic              busy;
  logic              done;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_rd;
  logic              mem_wr;
  logic [ROW_W-1:0]  row;
  logic              wr_en_a;
  logic              wr_en_b;
  logic              wr_en_c;
  logic              rd_en_c;
  logic              tpu_start;
`ifdef TPU_PERF_CNT_EN
  logic [31:0]       perf_busy_cycles;
`endif

  modport master (
    output op, op_valid, base_addr,
    input  stall, busy, done, mem_addr, mem_rd, mem_wr, row,
           wr_en_a, wr_en_b, wr_en_c, rd_en_c, tpu_start
`ifdef TPU_PERF_CNT_EN
    , input perf_busy_cycles
`endif
  );

  modport slave (
    input  op, op_valid, base_addr,
    output stall, busy, done, mem_addr, mem_rd, mem_wr, row,
           wr_en_a, wr_en_b, wr_en_c, rd_en_c, tpu_start
`ifdef TPU_PERF_CNT_EN
    , output perf_busy_cycles
`endif
  );

endinterface

// File: rtl/tpu_addr_gen.sv
// Row counter plus running base + k*ROW_STRIDE address, with one-cycle delayed
// copies of row and address for the second half of each transfer.
module tpu_addr_gen #(
  parameter int ADDR_W     = 16,
  parameter int ROW_STRIDE = 1,
  parameter int CNT_W      = 5,
  parameter int ROW_W      = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              adv,
  input  logic [ADDR_W-1:0] base,
  output logic [CNT_W-1:0]  cnt,
  output logic [ROW_W-1:0]  row,
  output logic [ROW_W-1:0]  row_d,
  output logic [ADDR_W-1:0] addr,
  output logic [ADDR_W-1:0] addr_d
);

  localparam logic [ADDR_W-1:0] STEP = ADDR_W'(ROW_STRIDE);

  // Additions truncate to ADDR_W, so the address wraps modulo 2^ADDR_W.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt    <= '0;
      row_d  <= '0;
      addr   <= '0;
      addr_d <= '0;
    end else if (clr) begin
      cnt    <= '0;
      row_d  <= '0;
      addr   <= base;
      addr_d <= '0;
    end else if (adv) begin
      cnt    <= cnt + CNT_W'(1);
      row_d  <= cnt[ROW_W-1:0];
      addr   <= addr + STEP;
      addr_d <= addr;
    end
  end

  assign row = cnt[ROW_W-1:0];

endmodule

// File: rtl/tpu_seq_ctrl.sv
// Multi-cycle sequencer for the TPU opcode group: row streaming and matmul timing.
// TPU_PERF_CNT_EN adds a saturating busy-cycle counter.
module tpu_seq_ctrl
  import tpu_ctrl_pkg::*;
#(
  parameter int DIM        = 8,
  parameter int ADDR_W     = 16,
  parameter int ROW_STRIDE = 1
) (
  input logic           clk,
  input logic           rst,
  tpu_seq_ctrl_if.slave bus
);

  localparam int ROW_W = row_w(DIM);
  localparam int CNT_W = $clog2(3*DIM + 1);
  localparam logic [CNT_W-1:0] LAST_ROW = CNT_W'(DIM);
  localparam logic [CNT_W-1:0] MM_LAST  = CNT_W'(3*DIM - 3);

  tpu_state_e        state, state_nx;
  logic [6:0]        op_q;
  logic              accept, adv, done, busy;
  logic [CNT_W-1:0]  cnt;
  logic [ROW_W-1:0]  row_cur, row_d, row;
  logic [ADDR_W-1:0] addr, addr_d, mem_addr;
  logic              mem_rd, mem_wr, wr_en_a, wr_en_b, wr_en_c, rd_en_c, tpu_start;

  assign accept = (state == IDLE) && bus.op_valid && is_tpu_op(bus.op);

  tpu_addr_gen #(
    .ADDR_W(ADDR_W), .ROW_STRIDE(ROW_STRIDE), .CNT_W(CNT_W), .ROW_W(ROW_W)
  ) u_addr_gen (
    .clk(clk), .rst(rst), .clr(accept), .adv(adv), .base(bus.base_addr),
    .cnt(cnt), .row(row_cur), .row_d(row_d), .addr(addr), .addr_d(addr_d)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      op_q  <= '0;
    end else begin
      state <= state_nx;
      if (accept) op_q <= bus.op;
    end
  end

  // Each transfer is DIM+1 cycles: the front strobe for rows 0..DIM-1, then the
  // back strobe one cycle behind it using the delayed row/address.
  always_comb begin
    state_nx  = state;
    adv       = 1'b0;
    done      = 1'b0;
    mem_rd    = 1'b0;
    mem_wr    = 1'b0;
    mem_addr  = '0;
    row       = '0;
    wr_en_a   = 1'b0;
    wr_en_b   = 1'b0;
    wr_en_c   = 1'b0;
    rd_en_c   = 1'b0;
    tpu_start = 1'b0;
    if (!rst) begin
      case (state)
        IDLE: begin
          if (accept) begin
            case (bus.op)
              OP_MATMUL: state_nx = MM;
              OP_RACC:   state_nx = STORE;
              default:   state_nx = LOAD;
            endcase
          end
        end
        LOAD: begin
          adv    = 1'b1;
          mem_rd = (cnt < LAST_ROW);
          if (mem_rd) mem_addr = addr;
          if (cnt != '0) begin
            row     = row_d;
            wr_en_a = (op_q == OP_LAM);
            wr_en_b = (op_q == OP_LBM);
            wr_en_c = (op_q == OP_LACC);
          end
          if (cnt == LAST_ROW) begin
            done     = 1'b1;
            state_nx = IDLE;
          end
        end
        STORE: begin
          adv     = 1'b1;
          rd_en_c = (cnt < LAST_ROW);
          if (rd_en_c) row = row_cur;
          mem_wr  = (cnt != '0);
          if (mem_wr) mem_addr = addr_d;
          if (cnt == LAST_ROW) begin
            done     = 1'b1;
            state_nx = IDLE;
          end
        end
        MM: begin
          adv       = 1'b1;
          tpu_start = (cnt == '0);
          if (cnt == MM_LAST) begin
            done     = 1'b1;
            state_nx = IDLE;
          end
        end
        default: state_nx = IDLE;
      endcase
    end
  end

  assign busy = !rst && (state != IDLE);

  assign bus.stall     = bus.op_valid && is_tpu_op(bus.op) && !done;
  assign bus.busy      = busy;
  assign bus.done      = done;
  assign bus.mem_addr  = mem_addr;
  assign bus.mem_rd    = mem_rd;
  assign bus.mem_wr    = mem_wr;
  assign bus.row       = row;
  assign bus.wr_en_a   = wr_en_a;
  assign bus.wr_en_b   = wr_en_b;
  assign bus.wr_en_c   = wr_en_c;
  assign bus.rd_en_c   = rd_en_c;
  assign bus.tpu_start = tpu_start;

`ifdef TPU_PERF_CNT_EN
  logic [31:0] perf_q;

  always_ff @(posedge clk) begin
    if (rst)                          perf_q <= '0;
    else if (busy && perf_q != '1)    perf_q <= perf_q + 32'd1;
  end

  assign bus.perf_busy_cycles = perf_q;
`endif

endmodule

// File: tb/tb_tpu_seq_ctrl.sv
// Randomised bench for tpu_seq_ctrl against an offset-from-accept timing model.
module tb_tpu_seq_ctrl;
  localparam int DIM    = 4;
  localparam int ADDR_W = 16;
  localparam int STRIDE = 1;
  localparam int ROW_W  = 2;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  tpu_seq_ctrl_if #(.DIM(DIM), .ADDR_W(ADDR_W)) bus ();
  tpu_seq_ctrl #(.DIM(DIM), .ADDR_W(ADDR_W), .ROW_STRIDE(STRIDE)) dut (
    .clk(clk), .rst(rst), .bus(bus)
  );

  int errors = 0;
  int checks = 0;
  int cyc    = 0;
  // reference model: the op in flight and the cycle it was accepted
  bit          act = 1'b0;
  int          t0  = 0;
  logic [6:0]  m_op = '0;
  logic [15:0] m_base = '0;
`ifdef TPU_PERF_CNT_EN
  logic [31:0] m_perf = '0;
`endif

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s cycle=%0d got=%0h expected=%0h", tag, cyc, got, exp);
    end
  endtask

  function automatic bit tpu_op(input logic [6:0] o);
    return (o >= 7'h50) && (o <= 7'h54);
  endfunction

  task automatic step(input bit v, input logic [6:0] o, input logic [15:0] b,
                      input bit r, output bit stl);
    logic e_rd, e_wr, e_a, e_b, e_c, e_rc, e_st, e_dn, e_busy, e_stall;
    logic [15:0]      e_addr;
    logic [ROW_W-1:0] e_row;
    int d;
    @(negedge clk);
    rst = r; bus.op_valid = v; bus.op = o; bus.base_addr = b;
    #1;
    {e_rd, e_wr, e_a, e_b, e_c, e_rc, e_st, e_dn, e_busy} = '0;
    e_addr = '0; e_row = '0;
    d = cyc - t0;
    if (!r && act) begin
      e_busy = 1'b1;
      if (m_op == 7'h50) begin
        e_st = (d == 1);
        e_dn = (d == 3*DIM - 2);
      end else if (m_op == 7'h54) begin
        e_rc = (d <= DIM);
        if (e_rc) e_row = ROW_W'(d - 1);
        e_wr = (d >= 2);
        if (e_wr) e_addr = 16'(m_base + (d - 2)*STRIDE);
        e_dn = (d == DIM + 1);
      end else begin
        e_rd = (d <= DIM);
        if (e_rd) e_addr = 16'(m_base + (d - 1)*STRIDE);
        if (d >= 2) begin
          e_row = ROW_W'(d - 2);
          e_a = (m_op == 7'h51);
          e_b = (m_op == 7'h52);
          e_c = (m_op == 7'h53);
        end
        e_dn = (d == DIM + 1);
      end
    end
    e_stall = v && tpu_op(o) && !e_dn;

    chk("stall", bus.stall, e_stall);
    chk("busy", bus.busy, e_busy);
    chk("done", bus.done, e_dn);
    chk("mem_rd", bus.mem_rd, e_rd);
    chk("mem_wr", bus.mem_wr, e_wr);
    chk("mem_addr", bus.mem_addr, e_addr);
    chk("row", bus.row, e_row);
    chk("wr_en_a", bus.wr_en_a, e_a);
    chk("wr_en_b", bus.wr_en_b, e_b);
    chk("wr_en_c", bus.wr_en_c, e_c);
    chk("rd_en_c", bus.rd_en_c, e_rc);
    chk("tpu_start", bus.tpu_start, e_st);
    chk("wr_onehot", 32'(bus.wr_en_a + bus.wr_en_b + bus.wr_en_c) <= 1, 1);
`ifdef TPU_PERF_CNT_EN
    chk("perf", bus.perf_busy_cycles, m_perf);
    if (r) m_perf = '0;
    else if (e_busy && m_perf != 32'hFFFF_FFFF) m_perf = m_perf + 1;
`endif
    stl = e_stall;

    if (r) act = 1'b0;
    else if (act && e_dn) act = 1'b0;
    else if (!act && v && tpu_op(o)) begin
      act = 1'b1; t0 = cyc; m_op = o; m_base = b;
    end
    cyc++;
  endtask

  // Present one instruction and hold it in decode while stalled; rst pulses at step rst_at.
  task automatic issue(input logic [6:0] o, input logic [15:0] b, input int rst_at);
    int n;
    bit stl;
    n = 0;
    do begin
      step(1'b1, o, b, (n == rst_at), stl);
      n++;
    end while (stl && n < 64);
    if (stl) chk("hold_timeout", stl, 0);
  endtask

  function automatic logic [6:0] pick_op();
    case ($urandom_range(0, 9))
      0, 1, 2, 3, 4: return 7'(7'h50 + $urandom_range(0, 4));
      5:             return 7'(7'h55 + $urandom_range(0, 10));
      6:             return 7'h01;
      7:             return 7'($urandom_range(0, 127));
      default:       return 7'(7'h50 + $urandom_range(0, 4));
    endcase
  endfunction

  function automatic logic [15:0] pick_base();
    case ($urandom_range(0, 3))
      0:       return 16'(16'hFFF8 + $urandom_range(0, 7));
      1:       return 16'($urandom_range(0, 15));
      default: return 16'($urandom_range(0, 65535));
    endcase
  endfunction

  initial begin
    bit stl;
    rst = 1'b1; bus.op_valid = 1'b0; bus.op = '0; bus.base_addr = '0;

    repeat (3) step(1'b0, 7'h00, 16'h0000, 1'b1, stl);
    step(1'b0, 7'h00, 16'h0000, 1'b0, stl);

    issue(7'h51, 16'h0100, -1);
    step(1'b0, 7'h00, 16'h0000, 1'b0, stl);
    issue(7'h50, 16'h0000, -1);
    step(1'b0, 7'h00, 16'h0000, 1'b0, stl);
    issue(7'h54, 16'hFFFE, -1);
    issue(7'h01, 16'h1234, -1);
    issue(7'h55, 16'h1234, -1);
    issue(7'h52, 16'h0200, -1);
    issue(7'h53, 16'h0300, -1);
    step(1'b0, 7'h00, 16'h0000, 1'b0, stl);
    issue(7'h51, 16'h0100, 3);

    for (int i = 0; i < 150; i++) begin
      if ($urandom_range(0, 3) == 0)
        step(1'b0, pick_op(), pick_base(), 1'b0, stl);
      else if ($urandom_range(0, 9) == 0)
        issue(pick_op(), pick_base(), $urandom_range(0, 12));
      else
        issue(pick_op(), pick_base(), -1);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog cycle=%0d got=timeout expected=finish", cyc);
    $fatal(1, "watchdog expired");
  end

endmodule
